scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter COLUMN_NUMBER, default 8: columns per frame, >=1.
REQ-002 SHALL have parameter BIT_PLANES, default 4: BCM bit planes per column, >=1.
REQ-003 SHALL have parameter BASE_ON_CYCLES, default 8: on-time of plane 0 in clk cycles, >=1.
REQ-004 SHALL have parameter BLANK_CYCLES, default 2: blanking time after each plane in clk cycles, >=1.
REQ-005 SHALL have port clk  in  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port start  in  1  frame start request pulse.
REQ-008 SHALL have port cs_ready  in  1  column_select idle/ready.
REQ-009 SHALL have port cs_select_first  out  1  one-cycle pulse: select column 0.
REQ-010 SHALL have port cs_select_next  out  1  one-cycle pulse: advance to next column.
REQ-011 SHALL have port row_load  out  1  one-cycle pulse: row driver loads data for row_col/row_plane.
REQ-012 SHALL have port row_col  out  $clog2(COLUMN_NUMBER) (min 1)  current column index.
REQ-013 SHALL have port row_plane  out  $clog2(BIT_PLANES) (min 1)  current bit plane.
REQ-014 SHALL have port row_done  in  1  row driver finished shifting and latching.
REQ-015 SHALL have port led_oe  out  1  display enable, active-high.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port frame_done  out  1  one-cycle pulse at end of last plane of last column.

Function
REQ-018 SHALL implement states IDLE, SEL_WAIT, SEL_ACK, SEL_BUSY, LOAD, LOAD_WAIT, DISPLAY, BLANK.
REQ-019 IDLE: start=1 -> col=0, plane=0, go SEL_WAIT.
REQ-020 SEL_WAIT: while cs_ready=0 stay; on cs_ready=1 pulse cs_select_first if col==0 else cs_select_next, go SEL_ACK.
REQ-021 SEL_ACK: one cycle, cs_ready ignored; then SEL_BUSY.
REQ-022 SEL_BUSY: on cs_ready=1 go LOAD; never both select pulses in one cycle.
REQ-023 LOAD: pulse row_load for exactly one cycle, go LOAD_WAIT; row_col/row_plane stable from LOAD until leaving BLANK.
REQ-024 LOAD_WAIT: on row_done=1 go DISPLAY; row_done outside LOAD_WAIT ignored.
REQ-025 DISPLAY: led_oe=1 for exactly BASE_ON_CYCLES << plane cycles, then BLANK.
REQ-026 led_oe SHALL be 0 in every state except DISPLAY, so column switches and row loads always occur blanked.
REQ-027 BLANK: led_oe=0 for exactly BLANK_CYCLES cycles, then: plane<BIT_PLANES-1 -> plane+1, LOAD; else plane=0 and col<COLUMN_NUMBER-1 -> col+1, SEL_WAIT; else frame end.
REQ-028 Frame end: frame_done=1 for one cycle on the BLANK exit cycle; next state SEL_WAIT with col=0 if start pending, else IDLE.
REQ-029 start while busy=1 SHALL set a pending flag (no overlap/abort); start on the frame-end cycle also sets it; flag cleared when consumed.
REQ-030 On-time counter width SHALL hold BASE_ON_CYCLES<<(BIT_PLANES-1) without overflow.
REQ-031 All outputs SHALL be registered; select/load pulses high one cycle after entering/exiting the qualifying state, fixed latency.
REQ-032 COLUMN_NUMBER=1 SHALL issue only cs_select_first per frame; BIT_PLANES=1 SHALL display plane 0 only.

Reset
REQ-033 rst=1 SHALL force IDLE: led_oe, busy, frame_done, cs_select_first, cs_select_next, row_load = 0; row_col, row_plane, counters, pending = 0.
REQ-034 rst asserted mid-frame SHALL blank led_oe asynchronously; after release no outputs pulse until a new start.

Verification
REQ-035 COLUMN_NUMBER=3, BIT_PLANES=2, BASE=4, BLANK=2, cs_ready=1 with 3-cycle drop after each select, row_done 2 cycles after row_load; start -> select_first, select_next, select_next; led_oe high runs 4,8 per column; one frame_done.
REQ-036 Same config, cs_ready held 0 for 20 cycles at frame start -> no select pulse, led_oe=0 until cs_ready=1.
REQ-037 row_done withheld 50 cycles in LOAD_WAIT -> led_oe stays 0, row_load pulses once only.
REQ-038 start pulsed during DISPLAY of column 1 -> current frame completes, frame_done, next frame begins with cs_select_first with no IDLE cycle; busy stays 1.
REQ-039 rst pulsed during DISPLAY -> led_oe=0 immediately, all outputs at reset values, idle until next start.
REQ-040 COLUMN_NUMBER=1, BIT_PLANES=1 -> per frame exactly one cs_select_first, one row_load, led_oe high 4 cycles, frame_done.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// Handshake bundle between the scan sequencer, the column selector and the row driver.
// The master modport is the sequencer's view; slave is the environment's view.
interface scan_sequencer_if #(
  parameter int COLUMN_NUMBER = 8,
  parameter int BIT_PLANES    = 4
);
  localparam int COL_W   = (COLUMN_NUMBER > 1) ? $clog2(COLUMN_NUMBER) : 1;
  localparam int PLANE_W = (BIT_PLANES > 1) ? $clog2(BIT_PLANES) : 1;

  logic               start;
  logic               cs_ready;
  logic               cs_select_first;
  logic               cs_select_next;
  logic               row_load;
  logic [COL_W-1:0]   row_col;
  logic [PLANE_W-1:0] row_plane;
  logic               row_done;
  logic               led_oe;
  logic               busy;
  logic               frame_done;

  modport master (
    input  start, cs_ready, row_done,
    output cs_select_first, cs_select_next, row_load, row_col, row_plane,
           led_oe, busy, frame_done
  );

  modport slave (
    output start, cs_ready, row_done,
    input  cs_select_first, cs_select_next, row_load, row_col, row_plane,
           led_oe, busy, frame_done
  );
endinterface

// File: rtl/scan_sequencer.sv
// LED matrix scan sequencer: per column select, then per bit plane load rows, display for a
// binary-weighted on-time and blank. All outputs come straight from flops.
module scan_sequencer #(
  parameter int COLUMN_NUMBER  = 8,
  parameter int BIT_PLANES     = 4,
  parameter int BASE_ON_CYCLES = 8,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  scan_sequencer_if.master   bus
);
  localparam int COL_W   = (COLUMN_NUMBER > 1) ? $clog2(COLUMN_NUMBER) : 1;
  localparam int PLANE_W = (BIT_PLANES > 1) ? $clog2(BIT_PLANES) : 1;
  localparam int ON_MAX  = BASE_ON_CYCLES << (BIT_PLANES - 1);
  localparam int CNT_MAX = (ON_MAX > BLANK_CYCLES) ? ON_MAX : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SEL_WAIT, SEL_ACK, SEL_BUSY, LOAD, LOAD_WAIT, DISPLAY, BLANK
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               sel_first_q, sel_first_d;
  logic               sel_next_q, sel_next_d;
  logic               row_load_q, row_load_d;
  logic               led_oe_q, led_oe_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               last_col;
  logic               last_plane;
  logic [CNT_W-1:0]   on_load;

  assign last_col   = (col_q == COL_W'(COLUMN_NUMBER - 1));
  assign last_plane = (plane_q == PLANE_W'(BIT_PLANES - 1));
  // Counter runs down to zero, so it is preloaded with the cycle count minus one.
  assign on_load    = (CNT_W'(BASE_ON_CYCLES) << plane_q) - CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    plane_d      = plane_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    sel_first_d  = 1'b0;
    sel_next_d   = 1'b0;
    row_load_d   = 1'b0;
    frame_done_d = 1'b0;

    if (bus.start && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          col_d   = '0;
          plane_d = '0;
          state_d = SEL_WAIT;
        end
      end
      SEL_WAIT: begin
        if (bus.cs_ready) begin
          sel_first_d = (col_q == '0);
          sel_next_d  = (col_q != '0);
          state_d     = SEL_ACK;
        end
      end
      SEL_ACK: begin
        // The selector may still report ready for a cycle after the pulse.
        state_d = SEL_BUSY;
      end
      SEL_BUSY: begin
        if (bus.cs_ready) begin
          row_load_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        state_d = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (bus.row_done) begin
          cnt_d   = on_load;
          state_d = DISPLAY;
        end
      end
      DISPLAY: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(BLANK_CYCLES - 1);
          state_d = BLANK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BLANK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!last_plane) begin
          plane_d    = plane_q + PLANE_W'(1);
          row_load_d = 1'b1;
          state_d    = LOAD;
        end else begin
          plane_d = '0;
          if (!last_col) begin
            col_d   = col_q + COL_W'(1);
            state_d = SEL_WAIT;
          end else begin
            frame_done_d = 1'b1;
            col_d        = '0;
            // A queued request (or one arriving right now) chains straight into the next frame.
            if (pending_q || bus.start) begin
              pending_d = 1'b0;
              state_d   = SEL_WAIT;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    led_oe_d = (state_d == DISPLAY);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      plane_q      <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      sel_first_q  <= 1'b0;
      sel_next_q   <= 1'b0;
      row_load_q   <= 1'b0;
      led_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      sel_first_q  <= sel_first_d;
      sel_next_q   <= sel_next_d;
      row_load_q   <= row_load_d;
      led_oe_q     <= led_oe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.cs_select_first = sel_first_q;
  assign bus.cs_select_next  = sel_next_q;
  assign bus.row_load        = row_load_q;
  assign bus.row_col         = col_q;
  assign bus.row_plane       = plane_q;
  assign bus.led_oe          = led_oe_q;
  assign bus.busy            = busy_q;
  assign bus.frame_done      = frame_done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: scenario table, hand-written corner cases and randomized frames
// checked against an event-sequence model of a frame.
module tb_scan_sequencer;
  localparam int CA   = 3;
  localparam int PA   = 2;
  localparam int BASE = 4;
  localparam int BLK  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scan_sequencer_if #(.COLUMN_NUMBER(CA), .BIT_PLANES(PA)) ifa ();
  scan_sequencer_if #(.COLUMN_NUMBER(1), .BIT_PLANES(1)) ifb ();

  scan_sequencer #(.COLUMN_NUMBER(CA), .BIT_PLANES(PA), .BASE_ON_CYCLES(BASE), .BLANK_CYCLES(BLK))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  scan_sequencer #(.COLUMN_NUMBER(1), .BIT_PLANES(1), .BASE_ON_CYCLES(BASE), .BLANK_CYCLES(BLK))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic start_a = 1'b0, cs_rdy_a, cs_hold_a = 1'b0, row_done_a;
  logic start_b = 1'b0, cs_rdy_b, row_done_b;
  assign ifa.start    = start_a;
  assign ifa.cs_ready = cs_rdy_a & ~cs_hold_a;
  assign ifa.row_done = row_done_a;
  assign ifb.start    = start_b;
  assign ifb.cs_ready = cs_rdy_b;
  assign ifb.row_done = row_done_b;

  int total = 0;
  int bad   = 0;

  // Event kinds: 1 select_first, 2 select_next, 3 load(col,plane), 4 on-run(len), 5 frame_done
  typedef struct { int kind; int a; int b; } ev_t;
  ev_t log_a[$];
  ev_t log_b[$];
  ev_t exp_q[$];
  int  fd_a = 0, fd_b = 0;
  int  on_run_a = 0, low_run_a = 0, on_run_b = 0;
  bit  fell_a = 1'b0;

  int drop_a = 3, dly_a = 2;
  bit rand_a = 1'b0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_min(string name, int act, int lo);
    total++;
    if (act < lo) begin
      bad++;
      $display("FAIL %s: got %0d want >= %0d", name, act, lo);
    end
  endtask

  // Environment models: selector drops ready after each select, row driver answers loads.
  initial begin
    cs_rdy_a = 1'b1;
    forever begin
      int d;
      @(negedge clk);
      if (!rst && (ifa.cs_select_first || ifa.cs_select_next)) begin
        d = rand_a ? int'($urandom_range(0, 5)) : drop_a;
        if (d > 0) begin
          @(posedge clk); #1 cs_rdy_a = 1'b0;
          repeat (d) @(posedge clk);
          #1 cs_rdy_a = 1'b1;
        end
      end
    end
  end

  initial begin
    row_done_a = 1'b0;
    forever begin
      int d;
      @(negedge clk);
      if (!rst && ifa.row_load) begin
        d = rand_a ? int'($urandom_range(1, 6)) : dly_a;
        repeat (d) @(posedge clk);
        #1 row_done_a = 1'b1;
        @(posedge clk); #1 row_done_a = 1'b0;
      end else if (rand_a && ifa.led_oe && ($urandom_range(0, 7) == 0)) begin
        // Stray row_done during display must be ignored.
        @(posedge clk); #1 row_done_a = 1'b1;
        @(posedge clk); #1 row_done_a = 1'b0;
      end
    end
  end

  initial begin
    cs_rdy_b = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && (ifb.cs_select_first || ifb.cs_select_next)) begin
        @(posedge clk); #1 cs_rdy_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 cs_rdy_b = 1'b1;
      end
    end
  end

  initial begin
    row_done_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && ifb.row_load) begin
        repeat (2) @(posedge clk);
        #1 row_done_b = 1'b1;
        @(posedge clk); #1 row_done_b = 1'b0;
      end
    end
  end

  // Monitors: turn output activity into an event log and check blanking rules on the fly.
  always @(negedge clk) begin
    if (ifa.cs_select_first) begin
      log_a.push_back('{1, 0, 0});
      chk("sel_exclusive", int'(ifa.cs_select_next), 0);
      chk("sel_blanked", int'(ifa.led_oe), 0);
    end else if (ifa.cs_select_next) begin
      log_a.push_back('{2, 0, 0});
      chk("sel_blanked", int'(ifa.led_oe), 0);
    end
    if (ifa.row_load) begin
      log_a.push_back('{3, int'(ifa.row_col), int'(ifa.row_plane)});
      chk("load_blanked", int'(ifa.led_oe), 0);
      chk("load_busy", int'(ifa.busy), 1);
    end
    if (ifa.led_oe) begin
      if (on_run_a == 0 && fell_a) chk_min("blank_gap", low_run_a, BLK);
      on_run_a  <= on_run_a + 1;
      low_run_a <= 0;
    end else begin
      if (on_run_a > 0) begin
        log_a.push_back('{4, on_run_a, 0});
        fell_a <= 1'b1;
      end
      on_run_a  <= 0;
      low_run_a <= low_run_a + 1;
    end
    if (ifa.frame_done) begin
      log_a.push_back('{5, 0, 0});
      fd_a <= fd_a + 1;
    end
  end

  always @(negedge clk) begin
    if (ifb.cs_select_first) log_b.push_back('{1, 0, 0});
    if (ifb.cs_select_next)  log_b.push_back('{2, 0, 0});
    if (ifb.row_load)        log_b.push_back('{3, int'(ifb.row_col), int'(ifb.row_plane)});
    if (ifb.led_oe) begin
      on_run_b <= on_run_b + 1;
    end else begin
      if (on_run_b > 0) log_b.push_back('{4, on_run_b, 0});
      on_run_b <= 0;
    end
    if (ifb.frame_done) begin
      log_b.push_back('{5, 0, 0});
      fd_b <= fd_b + 1;
    end
  end

  // Reference: what one frame must look like, derived from columns, planes and base time.
  task automatic gen_frames(int n, int ncol, int npl);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < ncol; c++) begin
        exp_q.push_back('{(c == 0) ? 1 : 2, 0, 0});
        for (int p = 0; p < npl; p++) begin
          exp_q.push_back('{3, c, p});
          exp_q.push_back('{4, BASE << p, 0});
        end
      end
      exp_q.push_back('{5, 0, 0});
    end
  endtask

  task automatic cmp_seq(string name, bit use_b, int base);
    int n_act;
    n_act = (use_b ? log_b.size() : log_a.size()) - base;
    chk({name, "_events"}, n_act, exp_q.size());
    for (int i = 0; i < n_act && i < exp_q.size(); i++) begin
      ev_t e;
      int  ca, ce;
      e  = use_b ? log_b[base + i] : log_a[base + i];
      ca = e.kind * 10000 + e.a * 100 + e.b;
      ce = exp_q[i].kind * 10000 + exp_q[i].a * 100 + exp_q[i].b;
      chk($sformatf("%s_ev%0d", name, i), ca, ce);
      if (ca != ce) break;
    end
    exp_q.delete();
  endtask

  task automatic cycle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_fd_a(int target, int budget);
    int n = 0;
    while (fd_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_reached", (fd_a >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (ifa.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(ifa.busy), 0);
    cycle(2);
  endtask

  task automatic run_frames_a(int n, int max_gap);
    int fd0;
    fd0 = fd_a;
    pulse_start_a();
    for (int i = 0; i < n; i++) begin
      cycle((max_gap > 5) ? int'($urandom_range(5, max_gap)) : 5);
      if (i < n - 1) pulse_start_a();
      wait_fd_a(fd0 + i + 1, 3000);
    end
  endtask

  typedef struct {
    int drop; int dly; int frames;
    int exp_sf; int exp_sn; int exp_ld; int exp_on; int exp_fd;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, fd0, viol, cnt_led, cnt_ld, busy_low, found, n;

    tbl[0] = '{3, 2, 1, 1, 2, 6, 36, 1};
    tbl[1] = '{0, 1, 1, 1, 2, 6, 36, 1};
    tbl[2] = '{5, 4, 2, 2, 4, 12, 72, 2};
    tbl[3] = '{1, 6, 3, 3, 6, 18, 108, 3};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_led_oe", int'(ifa.led_oe), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_frame_done", int'(ifa.frame_done), 0);
    chk("rst_sel_first", int'(ifa.cs_select_first), 0);
    chk("rst_sel_next", int'(ifa.cs_select_next), 0);
    chk("rst_row_load", int'(ifa.row_load), 0);
    chk("rst_row_col", int'(ifa.row_col), 0);
    chk("rst_row_plane", int'(ifa.row_plane), 0);
    chk("rst_b_busy", int'(ifb.busy), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle(3);
    chk("idle_after_rst", int'(ifa.busy), 0);

    // Scenario table
    for (int t = 0; t < 4; t++) begin
      int sf, sn, ld, on, fd;
      drop_a = tbl[t].drop;
      dly_a  = tbl[t].dly;
      base   = log_a.size();
      run_frames_a(tbl[t].frames, 5);
      wait_idle_a();
      sf = 0; sn = 0; ld = 0; on = 0; fd = 0;
      for (int i = base; i < log_a.size(); i++) begin
        case (log_a[i].kind)
          1: sf++;
          2: sn++;
          3: ld++;
          4: on += log_a[i].a;
          5: fd++;
          default: ;
        endcase
      end
      chk($sformatf("tbl%0d_sel_first", t), sf, tbl[t].exp_sf);
      chk($sformatf("tbl%0d_sel_next", t), sn, tbl[t].exp_sn);
      chk($sformatf("tbl%0d_loads", t), ld, tbl[t].exp_ld);
      chk($sformatf("tbl%0d_on_cycles", t), on, tbl[t].exp_on);
      chk($sformatf("tbl%0d_frame_done", t), fd, tbl[t].exp_fd);
      gen_frames(tbl[t].frames, CA, PA);
      cmp_seq($sformatf("tbl%0d_seq", t), 1'b0, base);
    end
    drop_a = 3;
    dly_a  = 2;

    // Selector not ready at frame start
    base = log_a.size();
    fd0  = fd_a;
    cs_hold_a = 1'b1;
    pulse_start_a();
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.cs_select_first || ifa.cs_select_next || ifa.led_oe || ifa.row_load) viol++;
    end
    chk("hold_no_activity", viol, 0);
    chk("hold_busy", int'(ifa.busy), 1);
    cs_hold_a = 1'b0;
    wait_fd_a(fd0 + 1, 3000);
    wait_idle_a();
    gen_frames(1, CA, PA);
    cmp_seq("hold_seq", 1'b0, base);

    // Row driver stalls
    base = log_a.size();
    fd0  = fd_a;
    dly_a = 50;
    pulse_start_a();
    n = 0;
    while (!ifa.row_load && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_load_seen", int'(ifa.row_load), 1);
    cnt_led = 0;
    cnt_ld  = 0;
    repeat (45) begin
      @(negedge clk);
      if (ifa.led_oe) cnt_led++;
      if (ifa.row_load) cnt_ld++;
    end
    chk("stall_led_off", cnt_led, 0);
    chk("stall_no_reload", cnt_ld, 0);
    wait_fd_a(fd0 + 1, 3000);
    wait_idle_a();
    dly_a = 2;
    gen_frames(1, CA, PA);
    cmp_seq("stall_seq", 1'b0, base);

    // Start during display of column 1 chains a second frame with no idle gap
    base = log_a.size();
    fd0  = fd_a;
    pulse_start_a();
    n = 0;
    while (!(ifa.led_oe && ifa.row_col == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("chain_col1_display", int'(ifa.led_oe && ifa.row_col == 1), 1);
    @(posedge clk); #1;
    pulse_start_a();
    wait_fd_a(fd0 + 1, 3000);
    busy_low = 0;
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      if (!ifa.busy) busy_low++;
      if (ifa.cs_select_first) found = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("chain_busy_held", busy_low, 0);
    chk("chain_sel_first", found, 1);
    wait_fd_a(fd0 + 2, 3000);
    wait_idle_a();
    gen_frames(2, CA, PA);
    cmp_seq("chain_seq", 1'b0, base);

    // Reset during display, with a start already queued
    pulse_start_a();
    cycle(3);
    pulse_start_a();
    n = 0;
    while (!ifa.led_oe && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_display_seen", int'(ifa.led_oe), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_led_oe", int'(ifa.led_oe), 0);
    chk("rst_async_busy", int'(ifa.busy), 0);
    chk("rst_async_col", int'(ifa.row_col), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifa.busy || ifa.led_oe || ifa.frame_done || ifa.cs_select_first ||
          ifa.cs_select_next || ifa.row_load) viol++;
    end
    chk("rst_stays_idle", viol, 0);

    // Randomized frames
    rand_a = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n    = int'($urandom_range(1, 3));
      base = log_a.size();
      run_frames_a(n, 30);
      wait_idle_a();
      gen_frames(n, CA, PA);
      cmp_seq($sformatf("rand%0d_seq", r), 1'b0, base);
    end
    rand_a = 1'b0;

    // Single column, single plane
    base = log_b.size();
    for (int f = 0; f < 2; f++) begin
      fd0 = fd_b;
      start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      n = 0;
      while (fd_b == fd0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("b_frame%0d_done", f), fd_b - fd0, 1);
      cycle(5);
      chk($sformatf("b_frame%0d_idle", f), int'(ifb.busy), 0);
    end
    gen_frames(2, 1, 1);
    cmp_seq("b_seq", 1'b1, base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
